// File: rtl/gray_counter_param_if.sv
// Control/status bundle for gray_counter_param: count/load/clear controls in,
// registered Gray/binary count and wrap flags out.
interface gray_counter_param_if #(
    parameter int unsigned WIDTH = 3
) ();
    logic             En;
    logic             Up;
    logic             Load;
    logic [WIDTH-1:0] LoadVal;
    logic             ClrFlags;
    logic [WIDTH-1:0] Output;
    logic [WIDTH-1:0] Binary;
    logic             Overflow;
    logic             Underflow;
    logic             Wrap;

    modport master (
        output En, Up, Load, LoadVal, ClrFlags,
        input  Output, Binary, Overflow, Underflow, Wrap
    );

    modport slave (
        input  En, Up, Load, LoadVal, ClrFlags,
        output Output, Binary, Overflow, Underflow, Wrap
    );
endinterface

// File: rtl/gray_counter_param.sv
// Parametrised up/down Gray-code counter with Gray-coded parallel load,
// sticky or pulsed overflow/underflow flags and a registered wrap pulse.
module gray_counter_param #(
    parameter int unsigned WIDTH  = 3,
    parameter bit          STICKY = 1'b1
) (
    input logic                Clk,
    input logic                Reset,
    gray_counter_param_if.slave bus
);

    if (WIDTH < 2 || WIDTH > 16) begin : gen_width_check
        $error("gray_counter_param: WIDTH must be in 2..16");
    end

    localparam logic [WIDTH-1:0] MaxCnt  = '1;
    localparam logic [WIDTH-1:0] ZeroCnt = '0;

    // Bit i of the binary value is the XOR of Gray bits [WIDTH-1:i].
    function automatic logic [WIDTH-1:0] gray2bin(input logic [WIDTH-1:0] g);
        logic [WIDTH-1:0] b;
        b[WIDTH-1] = g[WIDTH-1];
        for (int i = int'(WIDTH) - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    function automatic logic [WIDTH-1:0] bin2gray(input logic [WIDTH-1:0] b);
        return b ^ (b >> 1);
    endfunction

    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] gray_q, gray_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;
    logic             wrap_q, wrap_d;
    logic             ovf_evt, unf_evt;

    always_comb begin
        cnt_d   = cnt_q;
        ovf_evt = 1'b0;
        unf_evt = 1'b0;
        if (bus.Load) begin
            cnt_d = gray2bin(bus.LoadVal);
        end else if (bus.En) begin
            if (bus.Up) begin
                if (cnt_q == MaxCnt) begin
                    cnt_d   = ZeroCnt;
                    ovf_evt = 1'b1;
                end else begin
                    cnt_d = cnt_q + WIDTH'(1);
                end
            end else begin
                if (cnt_q == ZeroCnt) begin
                    cnt_d   = MaxCnt;
                    unf_evt = 1'b1;
                end else begin
                    cnt_d = cnt_q - WIDTH'(1);
                end
            end
        end
    end

    // A set event on the same edge as ClrFlags wins; the other flag still clears.
    always_comb begin
        gray_d = bin2gray(cnt_d);
        wrap_d = ovf_evt | unf_evt;
        if (STICKY) begin
            ovf_d = ovf_evt | (ovf_q & ~bus.ClrFlags);
            unf_d = unf_evt | (unf_q & ~bus.ClrFlags);
        end else begin
            ovf_d = ovf_evt;
            unf_d = unf_evt;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            cnt_q  <= '0;
            gray_q <= '0;
            ovf_q  <= 1'b0;
            unf_q  <= 1'b0;
            wrap_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            gray_q <= gray_d;
            ovf_q  <= ovf_d;
            unf_q  <= unf_d;
            wrap_q <= wrap_d;
        end
    end

    assign bus.Output    = gray_q;
    assign bus.Binary    = cnt_q;
    assign bus.Overflow  = ovf_q;
    assign bus.Underflow = unf_q;
    assign bus.Wrap      = wrap_q;

endmodule

// File: tb/tb_gray_counter_param.sv
// Bench for gray_counter_param: directed vector table (WIDTH=3, sticky),
// hand-written corner sequences and randomized runs against a counting model.
module tb_gray_counter_param;

    logic clk;
    logic rst3;
    logic rst4;
    int   n_cmp;
    int   n_err;

    gray_counter_param_if #(.WIDTH(3)) u_if3 ();
    gray_counter_param_if #(.WIDTH(4)) u_if4 ();

    gray_counter_param #(.WIDTH(3), .STICKY(1'b1)) u_dut3 (
        .Clk   (clk),
        .Reset (rst3),
        .bus   (u_if3.slave)
    );

    gray_counter_param #(.WIDTH(4), .STICKY(1'b0)) u_dut4 (
        .Clk   (clk),
        .Reset (rst4),
        .bus   (u_if4.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       en;
        logic       up;
        logic       load;
        logic [2:0] lv;
        logic       clr;
        logic [2:0] gray;
        logic [2:0] bin;
        logic       ovf;
        logic       unf;
        logic       wrap;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic en, input logic up, input logic load,
                                input logic [2:0] lv, input logic clr,
                                input logic [2:0] gray, input logic [2:0] bin,
                                input logic ovf, input logic unf, input logic wrap);
        vec_t v;
        v.en = en; v.up = up; v.load = load; v.lv = lv; v.clr = clr;
        v.gray = gray; v.bin = bin; v.ovf = ovf; v.unf = unf; v.wrap = wrap;
        return v;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Model counts with plain integers; a Gray load is decoded by searching
    // for the count whose Gray image matches.
    function automatic int gray_to_int(input int g, input int w);
        for (int n = 0; n < (1 << w); n++) begin
            if ((n ^ (n >> 1)) == g) return n;
        end
        return -1;
    endfunction

    task automatic model_step(input int w, input bit sticky, input bit en, input bit up,
                              input bit load, input int lv, input bit clr,
                              inout int cnt, inout bit ovf, inout bit unf, inout bit wrap);
        int top;
        bit so;
        bit su;
        top = (1 << w) - 1;
        so  = 1'b0;
        su  = 1'b0;
        if (load) begin
            cnt = gray_to_int(lv, w);
        end else if (en) begin
            if (up) begin
                if (cnt == top) begin cnt = 0; so = 1'b1; end
                else cnt = cnt + 1;
            end else begin
                if (cnt == 0) begin cnt = top; su = 1'b1; end
                else cnt = cnt - 1;
            end
        end
        wrap = so | su;
        if (sticky) begin
            ovf = so | (ovf & !clr);
            unf = su | (unf & !clr);
        end else begin
            ovf = so;
            unf = su;
        end
    endtask

    task automatic check3(input string tag, input int cnt, input bit ovf, input bit unf,
                          input bit wrap);
        check({tag, ".gray"}, int'(u_if3.Output), cnt ^ (cnt >> 1));
        check({tag, ".bin"}, int'(u_if3.Binary), cnt);
        check({tag, ".ovf"}, int'(u_if3.Overflow), int'(ovf));
        check({tag, ".unf"}, int'(u_if3.Underflow), int'(unf));
        check({tag, ".wrap"}, int'(u_if3.Wrap), int'(wrap));
    endtask

    task automatic check4(input string tag, input int cnt, input bit ovf, input bit unf,
                          input bit wrap);
        check({tag, ".gray"}, int'(u_if4.Output), cnt ^ (cnt >> 1));
        check({tag, ".bin"}, int'(u_if4.Binary), cnt);
        check({tag, ".ovf"}, int'(u_if4.Overflow), int'(ovf));
        check({tag, ".unf"}, int'(u_if4.Underflow), int'(unf));
        check({tag, ".wrap"}, int'(u_if4.Wrap), int'(wrap));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int  m_cnt;
        bit  m_ovf;
        bit  m_unf;
        bit  m_wrap;
        bit  r_en, r_up, r_ld, r_clr;
        int  r_lv;
        int  prev_gray;
        vec_t v;

        n_cmp = 0;
        n_err = 0;
        rst3 = 1'b1;
        rst4 = 1'b1;
        u_if3.En = 1'b0; u_if3.Up = 1'b0; u_if3.Load = 1'b0;
        u_if3.LoadVal = '0; u_if3.ClrFlags = 1'b0;
        u_if4.En = 1'b0; u_if4.Up = 1'b0; u_if4.Load = 1'b0;
        u_if4.LoadVal = '0; u_if4.ClrFlags = 1'b0;

        tick();
        check3("reset3", 0, 1'b0, 1'b0, 1'b0);
        check4("reset4", 0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst3 = 1'b0;
        rst4 = 1'b0;

        // en up ld lv clr | gray bin ovf unf wrap
        tbl.push_back(mk(1, 1, 0, 3'b000, 0, 3'b001, 3'd1, 0, 0, 0));
        tbl.push_back(mk(1, 1, 0, 3'b000, 0, 3'b011, 3'd2, 0, 0, 0));
        tbl.push_back(mk(1, 1, 0, 3'b000, 0, 3'b010, 3'd3, 0, 0, 0));
        tbl.push_back(mk(1, 1, 0, 3'b000, 0, 3'b110, 3'd4, 0, 0, 0));
        tbl.push_back(mk(1, 1, 0, 3'b000, 0, 3'b111, 3'd5, 0, 0, 0));
        tbl.push_back(mk(1, 1, 0, 3'b000, 0, 3'b101, 3'd6, 0, 0, 0));
        tbl.push_back(mk(1, 1, 0, 3'b000, 0, 3'b100, 3'd7, 0, 0, 0));
        tbl.push_back(mk(1, 1, 0, 3'b000, 0, 3'b000, 3'd0, 1, 0, 1));
        tbl.push_back(mk(1, 1, 0, 3'b000, 0, 3'b001, 3'd1, 1, 0, 0));
        tbl.push_back(mk(0, 1, 0, 3'b000, 1, 3'b001, 3'd1, 0, 0, 0));
        tbl.push_back(mk(1, 1, 0, 3'b000, 0, 3'b011, 3'd2, 0, 0, 0));
        tbl.push_back(mk(1, 1, 0, 3'b000, 0, 3'b010, 3'd3, 0, 0, 0));
        tbl.push_back(mk(1, 1, 0, 3'b000, 0, 3'b110, 3'd4, 0, 0, 0));
        tbl.push_back(mk(1, 1, 0, 3'b000, 0, 3'b111, 3'd5, 0, 0, 0));
        tbl.push_back(mk(1, 1, 0, 3'b000, 0, 3'b101, 3'd6, 0, 0, 0));
        tbl.push_back(mk(1, 1, 0, 3'b000, 0, 3'b100, 3'd7, 0, 0, 0));
        tbl.push_back(mk(1, 1, 0, 3'b000, 1, 3'b000, 3'd0, 1, 0, 1));
        tbl.push_back(mk(1, 0, 0, 3'b000, 0, 3'b100, 3'd7, 1, 1, 1));
        tbl.push_back(mk(1, 0, 0, 3'b000, 0, 3'b101, 3'd6, 1, 1, 0));
        tbl.push_back(mk(1, 1, 1, 3'b110, 0, 3'b110, 3'd4, 1, 1, 0));
        tbl.push_back(mk(1, 1, 0, 3'b000, 0, 3'b111, 3'd5, 1, 1, 0));
        tbl.push_back(mk(0, 0, 1, 3'b100, 1, 3'b100, 3'd7, 0, 0, 0));
        tbl.push_back(mk(0, 0, 1, 3'b000, 0, 3'b000, 3'd0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 3'b000, 0, 3'b100, 3'd7, 0, 1, 1));
        tbl.push_back(mk(1, 1, 0, 3'b000, 1, 3'b000, 3'd0, 1, 0, 1));
        tbl.push_back(mk(1, 1, 0, 3'b000, 0, 3'b001, 3'd1, 1, 0, 0));
        tbl.push_back(mk(1, 1, 0, 3'b000, 0, 3'b011, 3'd2, 1, 0, 0));
        tbl.push_back(mk(1, 1, 0, 3'b000, 0, 3'b010, 3'd3, 1, 0, 0));
        tbl.push_back(mk(1, 1, 0, 3'b000, 0, 3'b110, 3'd4, 1, 0, 0));
        tbl.push_back(mk(1, 1, 0, 3'b000, 0, 3'b111, 3'd5, 1, 0, 0));

        foreach (tbl[i]) begin
            v = tbl[i];
            u_if3.En = v.en; u_if3.Up = v.up; u_if3.Load = v.load;
            u_if3.LoadVal = v.lv; u_if3.ClrFlags = v.clr;
            tick();
            check($sformatf("vec%0d.gray", i), int'(u_if3.Output), int'(v.gray));
            check($sformatf("vec%0d.bin", i), int'(u_if3.Binary), int'(v.bin));
            check($sformatf("vec%0d.ovf", i), int'(u_if3.Overflow), int'(v.ovf));
            check($sformatf("vec%0d.unf", i), int'(u_if3.Underflow), int'(v.unf));
            check($sformatf("vec%0d.wrap", i), int'(u_if3.Wrap), int'(v.wrap));
        end
        u_if3.Load = 1'b0; u_if3.ClrFlags = 1'b0;

        // Asynchronous reset between edges at count 5 with Overflow held.
        u_if3.En = 1'b1; u_if3.Up = 1'b1;
        #2;
        rst3 = 1'b1;
        #1;
        check3("async_rst", 0, 1'b0, 1'b0, 1'b0);
        #2;
        rst3 = 1'b0;
        tick();
        check3("after_rst", 1, 1'b0, 1'b0, 1'b0);

        // Randomized run, sticky WIDTH=3.
        m_cnt = 1; m_ovf = 1'b0; m_unf = 1'b0; m_wrap = 1'b0;
        for (int i = 0; i < 400; i++) begin
            r_en  = ($urandom_range(0, 3) != 0);
            r_up  = $urandom_range(0, 1) == 1;
            r_ld  = ($urandom_range(0, 7) == 0);
            r_lv  = $urandom_range(0, 7);
            r_clr = ($urandom_range(0, 3) == 0);
            u_if3.En = r_en; u_if3.Up = r_up; u_if3.Load = r_ld;
            u_if3.LoadVal = 3'(r_lv); u_if3.ClrFlags = r_clr;
            tick();
            model_step(3, 1'b1, r_en, r_up, r_ld, r_lv, r_clr, m_cnt, m_ovf, m_unf, m_wrap);
            check3($sformatf("rnd3_%0d", i), m_cnt, m_ovf, m_unf, m_wrap);
        end
        u_if3.En = 1'b0; u_if3.Load = 1'b0; u_if3.ClrFlags = 1'b0;

        // WIDTH=4, pulsed flags: 14 -> 15 -> 0 -> 1.
        u_if4.Load = 1'b1; u_if4.LoadVal = 4'b1001;
        tick();
        u_if4.Load = 1'b0;
        check4("w4_load14", 14, 1'b0, 1'b0, 1'b0);
        u_if4.En = 1'b1; u_if4.Up = 1'b1;
        tick();
        check4("w4_up15", 15, 1'b0, 1'b0, 1'b0);
        tick();
        check4("w4_wrap0", 0, 1'b1, 1'b0, 1'b1);
        tick();
        check4("w4_up1", 1, 1'b0, 1'b0, 1'b0);

        // 32 mixed steps: one Output bit changes per step, model tracks count.
        m_cnt = 1; m_ovf = 1'b0; m_unf = 1'b0; m_wrap = 1'b0;
        for (int i = 0; i < 32; i++) begin
            prev_gray = int'(u_if4.Output);
            r_up  = $urandom_range(0, 1) == 1;
            r_clr = $urandom_range(0, 1) == 1;
            u_if4.En = 1'b1; u_if4.Up = r_up; u_if4.ClrFlags = r_clr;
            tick();
            model_step(4, 1'b0, 1'b1, r_up, 1'b0, 0, r_clr, m_cnt, m_ovf, m_unf, m_wrap);
            check($sformatf("w4_onebit_%0d", i),
                  $countones(4'(prev_gray) ^ u_if4.Output), 1);
            check4($sformatf("w4_mix_%0d", i), m_cnt, m_ovf, m_unf, m_wrap);
        end

        // Randomized run, pulsed WIDTH=4.
        for (int i = 0; i < 300; i++) begin
            r_en  = ($urandom_range(0, 3) != 0);
            r_up  = $urandom_range(0, 1) == 1;
            r_ld  = ($urandom_range(0, 7) == 0);
            r_lv  = $urandom_range(0, 15);
            r_clr = ($urandom_range(0, 3) == 0);
            u_if4.En = r_en; u_if4.Up = r_up; u_if4.Load = r_ld;
            u_if4.LoadVal = 4'(r_lv); u_if4.ClrFlags = r_clr;
            tick();
            model_step(4, 1'b0, r_en, r_up, r_ld, r_lv, r_clr, m_cnt, m_ovf, m_unf, m_wrap);
            check4($sformatf("rnd4_%0d", i), m_cnt, m_ovf, m_unf, m_wrap);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
